// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

  // Step-counter width: $clog2 of the operand width, never below one bit.
  function automatic int unsigned div_cnt_w(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div32_if.sv
// Operand/result handshake bundle between the divider and its datapath.
interface div32_if #(
  parameter int unsigned DATA_WIDTH = div_pkg::DIV_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  shift_msb,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] next_rem,
  output logic                  qbit
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] trial;
  logic                borrow;

  always_comb begin
    shifted           = {rem, shift_msb};
    {borrow, trial}   = {1'b0, shifted} - {2'b00, divisor};
    qbit              = ~borrow;
    // rem < divisor on entry, so the kept value always fits DATA_WIDTH bits
    next_rem          = qbit ? DATA_WIDTH'(trial) : DATA_WIDTH'(shifted);
  end

endmodule

// File: rtl/div32.sv
// Iterative unsigned radix-2 restoring divider: one quotient bit per clock,
// result held until the consumer takes it, divide-by-zero flagged.
module div32
  import div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DIV_WIDTH
) (
  input  logic   clk,
  input  logic   rst,
  div32_if.slave bus
);

  localparam int unsigned CNT_W = div_cnt_w(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  div_state_e            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] dvsr;
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_qbit;

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem      (rem_q),
    .shift_msb(shreg[DATA_WIDTH-1]),
    .divisor  (dvsr),
    .next_rem (step_rem),
    .qbit     (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      rem_q           <= '0;
      shreg           <= '0;
      dvsr            <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            if (bus.divisor != '0) begin
              dvsr  <= bus.divisor;
              rem_q <= '0;
              shreg <= bus.dividend;
              cnt   <= '0;
              state <= CALC;
            end else begin
              // Zero divisor skips the iteration entirely
              bus.quotient    <= {DATA_WIDTH{1'b1}};
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.out_valid   <= 1'b1;
              state           <= DONE;
            end
          end
        end

        CALC: begin
          rem_q <= step_rem;
          shreg <= {shreg[DATA_WIDTH-2:0], step_qbit};
          if (cnt == LAST_STEP) begin
            bus.quotient    <= {shreg[DATA_WIDTH-2:0], step_qbit};
            bus.remainder   <= step_rem;
            bus.div_by_zero <= 1'b0;
            bus.out_valid   <= 1'b1;
            state           <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: directed table, multi-cycle corner sequences
// and randomised traffic, all checked through an in-order result scoreboard.
module tb_div32;
  import div_pkg::*;

  localparam int unsigned W = DIV_WIDTH;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  div32_if #(.DATA_WIDTH(W)) bus ();

  div32 #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  vec_t sb[$];
  vec_t vecs[7];
  int   n_vec    = 0;
  int   n_fail   = 0;
  int   rdy_mode = 0;   // 0: out_ready high, 1: out_ready low, 2: random

  function automatic vec_t mk(input logic [W-1:0] n, input logic [W-1:0] d,
                              input logic [W-1:0] q, input logic [W-1:0] r,
                              input logic dbz);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.r = r; v.dbz = dbz;
    return v;
  endfunction

  function automatic vec_t model(input logic [W-1:0] n, input logic [W-1:0] d);
    if (d == '0) return mk(n, d, DIV0_QUOTIENT, n, 1'b1);
    return mk(n, d, n / d, n % d, 1'b0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Pops and compares one expected record per completed output handshake
  task automatic monitor();
    vec_t        e;
    logic        ok;
    logic [63:0] recon;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          flag_fail("unexpected_result");
        end else begin
          e  = sb.pop_front();
          ok = (bus.quotient === e.q) && (bus.remainder === e.r) &&
               (bus.div_by_zero === e.dbz);
          if (!e.dbz) begin
            recon = 64'(bus.quotient) * 64'(e.d) + 64'(bus.remainder);
            ok = ok && (recon == 64'(e.n)) && (bus.remainder < e.d);
          end
          n_vec++;
          if (!ok) begin
            n_fail++;
            $display("FAIL result %0d/%0d: got q=0x%0h r=0x%0h dbz=%0b, expected q=0x%0h r=0x%0h dbz=%0b",
                     e.n, e.d, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.dbz);
          end
        end
      end
    end
  endtask

  task automatic rdy_driver();
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // Holds in_valid until accepted; returns one tick after the accepting edge
  task automatic send(input vec_t v);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.dividend = v.n;
    bus.divisor  = v.d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(v);
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    if (!ok) flag_fail("accept_timeout");
  endtask

  // Counts edges after the accepting edge until out_valid is observed high
  task automatic wait_valid(output int edges);
    bit ok;
    ok    = 1'b0;
    edges = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    if (!ok) flag_fail("valid_timeout");
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag_fail("drain_timeout");
  endtask

  initial begin
    int           edges;
    logic [W-1:0] rn;
    logic [W-1:0] rd;
    int           sel;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.out_ready = 1'b0;

    vecs[0] = mk(W'(100),          W'(7),          W'(14),         W'(2),     1'b0);
    vecs[1] = mk(W'(32'hFFFFFFFF), W'(1),          W'(32'hFFFFFFFF), W'(0),   1'b0);
    vecs[2] = mk(W'(32'hFFFFFFFF), W'(32'hFFFFFFFF), W'(1),       W'(0),     1'b0);
    vecs[3] = mk(W'(0),            W'(5),          W'(0),          W'(0),     1'b0);
    vecs[4] = mk(W'(3),            W'(10),         W'(0),          W'(3),     1'b0);
    vecs[5] = mk(W'(12345),        W'(0),          W'(32'hFFFFFFFF), W'(12345), 1'b1);
    vecs[6] = mk(W'(12),           W'(4),          W'(3),          W'(0),     1'b0);

    fork
      monitor();
      rdy_driver();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready",  64'(bus.in_ready),    64'(1));
    check("reset_out_valid", 64'(bus.out_valid),   64'(0));
    check("reset_quotient",  64'(bus.quotient),    64'(0));
    check("reset_remainder", 64'(bus.remainder),   64'(0));
    check("reset_dbz",       64'(bus.div_by_zero), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send(vecs[i]);
      wait_valid(edges);
      check(vecs[i].dbz ? "dbz_valid_edges" : "valid_edges", 64'(edges),
            vecs[i].dbz ? 64'(0) : 64'(W));
      @(posedge clk);
      @(negedge clk);
      check("ready_after_consume", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
      drain();
    end

    // Backpressure: result held while out_ready is low, in_valid pulses ignored
    rdy_mode = 1;
    @(posedge clk);
    #2;
    send(mk(W'(50), W'(6), W'(8), W'(2), 1'b0));
    wait_valid(edges);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i % 2 == 1);
      bus.dividend = W'(77);
      bus.divisor  = W'(0);
      @(negedge clk);
      check("hold_quotient",  64'(bus.quotient),  64'(8));
      check("hold_remainder", 64'(bus.remainder), 64'(2));
      check("hold_flags",     64'({bus.out_valid, bus.in_ready}), 64'(2'b10));
    end
    rdy_mode = 0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus.out_valid) break;
    end
    check("bp_released", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));
    check("bp_sb_empty", 64'(sb.size()), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("single_handshake", 64'(bus.out_valid), 64'(0));
    end

    // Asynchronous reset during step 10 of 1000/3
    send(mk(W'(1000), W'(3), W'(333), W'(1), 1'b0));
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midop_in_ready",  64'(bus.in_ready),    64'(1));
    check("midop_out_valid", 64'(bus.out_valid),   64'(0));
    check("midop_quotient",  64'(bus.quotient),    64'(0));
    check("midop_remainder", 64'(bus.remainder),   64'(0));
    check("midop_dbz",       64'(bus.div_by_zero), 64'(0));
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    send(mk(W'(1000), W'(3), W'(333), W'(1), 1'b0));
    wait_valid(edges);
    check("post_reset_valid_edges", 64'(edges), 64'(W));
    drain();

    // Random operands with random issue gaps and output stalls
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      rn  = W'($urandom);
      sel = int'($urandom_range(0, 15));
      if (sel == 0)      rd = '0;
      else if (sel <= 5) rd = W'($urandom_range(1, 15));
      else if (sel == 6) rd = rn;
      else               rd = W'($urandom >> $urandom_range(0, 31));
      send(model(rn, rd));
    end
    drain();
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("final_sb_empty", 64'(sb.size()), 64'(0));
    check("final_idle", 64'({bus.in_ready, bus.out_valid}), 64'(2'b10));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
